lighthouse_scan_arbiter: RTL
============================

LIGHTHOUSE_SCAN_ARBITER -- requirements
Module: lighthouse_scan_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, number of sensor decoder channels.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, result FIFO entries (power of two).
REQ-003 SHALL have port clock  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ch_valid  input  NUM_CH  per-channel result available; held by the channel until acked.
REQ-006 SHALL have port ch_data  input  NUM_CH*32  per-channel combined_data; channel i occupies bits [32i+31:32i].
REQ-007 SHALL have port ch_ack  output  NUM_CH  one-cycle, one-hot acknowledge; the channel drops valid after it.
REQ-008 SHALL have port address  input  3  Avalon word address.
REQ-009 SHALL have ports write/read  input  1 each  Avalon strobes.
REQ-010 SHALL have port writedata  input  32  Avalon write data.
REQ-011 SHALL have port readdata  output  32  Avalon read data, combinational from address.
REQ-012 SHALL have port waitrequest  output  1  tied 0.

Function
REQ-013 Register map: 0 R ID 0x0000_0006; 1 R status {overflow bit 8, count bits 4:0}; 2 R head channel id (peek, 0 if empty); 3 R head data, pop on read; 4 RW enable mask [NUM_CH-1:0]; 5 W command (bit0 flush, bit1 clear overflow); others read 0xDEAD_BEEF.
REQ-014 FSM states SCAN, CAPTURE, PUSH.
REQ-015 SCAN: when FIFO not full and any (ch_valid & enable) set, select the first requesting channel at or after last_grant+1 (wrapping NUM_CH-1 -> 0); record id; go CAPTURE.
REQ-016 CAPTURE: assert ch_ack[id] for exactly this cycle; register ch_data slice and id; go PUSH.
REQ-017 PUSH: write {id, data} into FIFO; set last_grant=id; go SCAN.
REQ-018 Latency: valid seen in SCAN at cycle N -> ack at N+1 -> FIFO entry visible at N+3.
REQ-019 A FIFO full in SCAN stalls there; no ack issued (backpressure, no loss).
REQ-020 A PUSH into a full FIFO (only possible if flush raced) drops the entry and sets overflow.
REQ-021 Read of address 3 when empty returns 0xFFFF_FFFF, no pop, count unchanged.
REQ-022 Pop and push in the same cycle: count unchanged, both take effect.
REQ-023 Flush clears FIFO pointers and count next cycle; a same-cycle PUSH is discarded; FSM returns to SCAN.
REQ-024 Channels disabled in the mask are never granted; disabling mid-CAPTURE still completes that transaction.
REQ-025 Count width log2(FIFO_DEPTH)+1; full at count == FIFO_DEPTH.

Reset
REQ-026 Reset SHALL force state SCAN, ch_ack 0, last_grant NUM_CH-1, enable mask all ones, FIFO empty, overflow 0.
REQ-027 Reset mid-CAPTURE/PUSH abandons the in-flight entry; the channel, if not yet acked, retains valid.

Structure
REQ-028 Package lighthouse_pkg SHALL hold NUM_CH, FIFO_DEPTH, register addresses, ID constant 0x0000_0006, FSM state type.
REQ-029 FIFO SHALL be sub-module lh_result_fifo (synchronous, single clock, data width 32+log2(NUM_CH), push/pop/flush/full/empty/count).

Verification
REQ-030 ch 3 valid, data 0x1234_5678 -> ack[3] at N+1, reg2 = 3, reg3 = 0x1234_5678, then count 0.
REQ-031 ch 0,5,15 valid simultaneously, last_grant 15 -> grant order 0,5,15; FIFO ids 0,5,15.
REQ-032 16 entries filled, ch 2 valid -> no ack[2], count 16; one pop -> ack[2] follows, count returns to 16.
REQ-033 Mask 0xFFF7, ch 3 valid -> never acked; reg3 read on empty -> 0xFFFF_FFFF.
REQ-034 Flush written while ch 7 in PUSH -> count 0, entry absent, overflow 0.
REQ-035 Reset asserted during CAPTURE -> ch_ack 0 immediately, count 0, reg4 = 0xFFFF.

Source files
------------

// File: rtl/lighthouse_pkg.sv
// Shared constants and types for the lighthouse scan arbiter slice.
package lighthouse_pkg;

  localparam int NUM_CH     = 16;
  localparam int FIFO_DEPTH = 16;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_HEAD_ID   = 3'd2;
  localparam logic [2:0] ADDR_HEAD_DATA = 3'd3;
  localparam logic [2:0] ADDR_ENABLE    = 3'd4;
  localparam logic [2:0] ADDR_CMD       = 3'd5;

  localparam logic [31:0] LH_ID_VALUE     = 32'h0000_0006;
  localparam logic [31:0] UNMAPPED_VALUE  = 32'hDEAD_BEEF;
  localparam logic [31:0] EMPTY_POP_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_CAPTURE,
    ST_PUSH
  } state_t;

endpackage

// File: rtl/lh_result_fifo.sv
// Single-clock result FIFO with flush; pushes into a full FIFO are dropped.
module lh_result_fifo #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = lighthouse_pkg::FIFO_DEPTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [DATA_W-1:0]       i_wdata,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_rdata  = r_mem[r_rdPtr];

  // Flush wins over everything else in the same cycle.
  assign w_doPush = i_push && !o_full && !i_flush;
  assign w_doPop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + (AW+1)'(w_doPush) - (AW+1)'(w_doPop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/lighthouse_scan_arbiter.sv
// Round-robin arbiter collecting sensor decoder results into a FIFO,
// exposed to the host through a small Avalon-MM register window.
module lighthouse_scan_arbiter #(
  parameter int NUM_CH     = lighthouse_pkg::NUM_CH,
  parameter int FIFO_DEPTH = lighthouse_pkg::FIFO_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH*32-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_ack,
  input  logic [2:0]           address,
  input  logic                 write,
  input  logic                 read,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 waitrequest
);
  import lighthouse_pkg::*;

  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DW  = 32 + IDW;

  state_t            r_state;
  state_t            w_next;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    r_lastGrant;
  logic [31:0]       r_data;
  logic [NUM_CH-1:0] r_enable;
  logic              r_overflow;

  logic [NUM_CH-1:0] w_req;
  logic [IDW-1:0]    w_idx;
  logic [IDW-1:0]    w_pick;
  logic              w_found;
  logic [31:0]       w_slice;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_clearOvf;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [DW-1:0]     w_head;
  logic [31:0]       w_status;
  logic              w_unused;

  assign w_req       = ch_valid & r_enable;
  assign w_push      = (r_state == ST_PUSH);
  assign w_pop       = read && (address == ADDR_HEAD_DATA) && !w_empty;
  assign w_flush     = write && (address == ADDR_CMD) && writedata[0];
  assign w_clearOvf  = write && (address == ADDR_CMD) && writedata[1];
  assign waitrequest = 1'b0;
  assign w_unused    = ^writedata[31:NUM_CH];

  // First requester strictly after the last grant, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = IDW'((int'(r_lastGrant) + k) % NUM_CH);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_slice = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_id == IDW'(i)) w_slice = ch_data[32*i +: 32];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_SCAN:    if (!w_full && w_found) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_PUSH;
      ST_PUSH:    w_next = ST_SCAN;
      default:    w_next = ST_SCAN;
    endcase
    if (w_flush) w_next = ST_SCAN;
  end

  always_comb begin
    ch_ack = '0;
    if (r_state == ST_CAPTURE) ch_ack[r_id] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_SCAN;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_id        <= '0;
      r_lastGrant <= IDW'(NUM_CH - 1);
      r_data      <= '0;
      r_enable    <= '1;
      r_overflow  <= 1'b0;
    end else begin
      if (r_state == ST_SCAN && w_next == ST_CAPTURE) r_id <= w_pick;
      if (r_state == ST_CAPTURE) r_data <= w_slice;
      if (r_state == ST_PUSH) r_lastGrant <= r_id;
      if (write && address == ADDR_ENABLE) r_enable <= writedata[NUM_CH-1:0];
      if (w_clearOvf)                          r_overflow <= 1'b0;
      else if (w_push && w_full && !w_flush)   r_overflow <= 1'b1;
    end
  end

  lh_result_fifo #(
    .DATA_W (DW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata ({r_id, r_data}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status           = '0;
    w_status[8]        = r_overflow;
    w_status[CW-1:0]   = w_count;
    readdata           = UNMAPPED_VALUE;
    case (address)
      ADDR_ID:        readdata = LH_ID_VALUE;
      ADDR_STATUS:    readdata = w_status;
      ADDR_HEAD_ID:   readdata = w_empty ? 32'h0 : 32'(w_head[DW-1:32]);
      ADDR_HEAD_DATA: readdata = w_empty ? EMPTY_POP_VALUE : w_head[31:0];
      ADDR_ENABLE:    readdata = 32'(r_enable);
      ADDR_CMD:       readdata = 32'h0;
      default:        readdata = UNMAPPED_VALUE;
    endcase
  end

endmodule
